// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared defaults, reserved-address base and word type for data_mem
package data_mem_pkg;

  localparam int DEFAULT_ADDR_W = 12;
  localparam int DEFAULT_DATA_W = 8;

  // The CPU reserves the first eight data addresses for special registers.
  localparam int DATA_MEM_SPECIAL_BASE = 8;

  typedef logic [DEFAULT_DATA_W-1:0] word_t;

endpackage

// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - address and strobe bundle of the data_mem bus
interface data_mem_if
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic [ADDR_W-1:0] addr;
  logic              rd;
  logic              wr;
  logic              en;

  // The CPU or bench issues the access.
  modport master (output addr, output rd, output wr, output en);

  // The memory observes the access.
  modport slave (input addr, input rd, input wr, input en);

endinterface

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - word storage with synchronous write and combinational read (macro DATA_MEM_ZERO_INIT_EN)
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 1 << DEFAULT_ADDR_W,
  parameter int IDX_W  = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

`ifdef DATA_MEM_ZERO_INIT_EN
  // Reset clears every word; outside reset the addressed word takes the bus value.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end
`else
  // Contents survive reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (we_i && reset_) begin
      mem_q[addr_i] <= wdata_i;
    end
  end
`endif

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem.sv
// rtl/data_mem.sv - byte RAM on a shared tri-state bus with range check (macro DATA_MEM_ZERO_INIT_EN)
module data_mem
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset_,
  inout  wire [DATA_W-1:0]  data,
  data_mem_if.slave         bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic              in_range;
  logic              we;
  logic              drive;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] rd_word;

  // Decode the access: writes beat reads, so the memory never fights the writer.
  always_comb begin
    in_range = ({1'b0, bus.addr} < DEPTH_LIM);
    we       = bus.en && bus.wr && in_range;
    drive    = reset_ && bus.en && bus.rd && !bus.wr;
    rd_word  = in_range ? rdata : '0;
  end

  data_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .reset_  (reset_),
    .we_i    (we),
    .addr_i  (bus.addr[IDX_W-1:0]),
    .wdata_i (data),
    .rdata_o (rdata)
  );

  // Reset drops drive immediately because it is part of the combinational enable.
  assign data = drive ? rd_word : 'z;

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - scoreboard bench for data_mem (macro DATA_MEM_ZERO_INIT_EN)
module tb_data_mem;
  import data_mem_pkg::*;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 2048;

`ifdef DATA_MEM_ZERO_INIT_EN
  localparam word_t RST_EXP = 8'h00;
`else
  localparam word_t RST_EXP = 8'h5A;
`endif

  logic       clk = 1'b0;
  logic       reset_;
  word_t      drv;
  logic       drv_en;
  wire [DW-1:0] data_bus;

  always #5 clk = ~clk;

  data_mem_if #(.ADDR_W(AW)) bus ();

  assign data_bus = drv_en ? drv : 'z;

  data_mem #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk    (clk),
    .reset_ (reset_),
    .data   (data_bus),
    .bus    (bus)
  );

  typedef struct {
    string name;
    word_t exp;
    bit    filt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Monitor: whenever an expectation is pending, sample the bus mid-cycle and compare.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      word_t got;
      e   = exp_q.pop_front();
      got = data_bus;
      if (e.filt) begin
        for (int b = 0; b < DW; b++) begin
          if (got[b] !== 1'b1) got[b] = 1'b0;
        end
      end
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h, required %h", e.name, got, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_bus(input string n, input word_t v, input bit f);
    exp_t e;
    e.name = n;
    e.exp  = v;
    e.filt = f;
    exp_q.push_back(e);
  endtask

  task automatic set_bus(input logic e, input logic r, input logic w, input logic [AW-1:0] a);
    bus.en   = e;
    bus.rd   = r;
    bus.wr   = w;
    bus.addr = a;
  endtask

  task automatic wr_word(input logic [AW-1:0] a, input word_t d);
    set_bus(1'b1, 1'b0, 1'b1, a);
    drv    = d;
    drv_en = 1'b1;
    tick();
    set_bus(1'b0, 1'b0, 1'b0, a);
    drv_en = 1'b0;
  endtask

  task automatic rd_check(input logic [AW-1:0] a, input word_t v, input string n, input bit f);
    set_bus(1'b1, 1'b1, 1'b0, a);
    drv_en = 1'b0;
    expect_bus(n, v, f);
    tick();
    set_bus(1'b0, 1'b0, 1'b0, a);
  endtask

  // Bench drives a pattern; if the memory also drives, the bus no longer equals it.
  task automatic probe(input logic e, input logic r, input logic w, input logic [AW-1:0] a,
                       input word_t p, input string n);
    set_bus(e, r, w, a);
    drv    = p;
    drv_en = 1'b1;
    expect_bus(n, p, 1'b0);
    tick();
    set_bus(1'b0, 1'b0, 1'b0, a);
    drv_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] base;
    base   = AW'(DATA_MEM_SPECIAL_BASE);
    reset_ = 1'b0;
    drv    = '0;
    drv_en = 1'b0;
    set_bus(1'b0, 1'b0, 1'b0, '0);
    tick();
    tick();

    probe(1'b1, 1'b1, 1'b0, base, 8'h5A, "reset_state_release");
    reset_ = 1'b1;
    tick();

    wr_word(base, 8'hA5);
    rd_check(base, 8'hA5, "write_then_read", 1'b0);
    probe(1'b1, 1'b0, 1'b0, base, 8'h5A, "rd0_release");

    wr_word(12'h010, 8'hC3);
    probe(1'b1, 1'b1, 1'b1, 12'h010, 8'h3C, "rd_wr_release");
    probe(1'b0, 1'b1, 1'b0, 12'h010, 8'hC3, "en0_release");
    rd_check(12'h010, 8'h3C, "rd_wr_write_landed", 1'b0);

    set_bus(1'b1, 1'b0, 1'b1, base);
    drv_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.addr = base + AW'(i);
      drv      = word_t'(i);
      tick();
    end
    set_bus(1'b0, 1'b0, 1'b0, base);
    drv_en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rd_check(base + AW'(i), word_t'(i), "fill_readback", 1'b0);
    end
    rd_check(12'h7FF, 8'h00, "unwritten_read_filtered", 1'b1);

    wr_word(12'h900, 8'h77);
    rd_check(12'h900, 8'h00, "out_of_range_read", 1'b0);
    rd_check(12'h100, 8'hF8, "alias_unaffected", 1'b0);

    wr_word(12'h020, 8'h5A);
    reset_ = 1'b0;
    set_bus(1'b1, 1'b0, 1'b1, 12'h020);
    drv    = 8'hFF;
    drv_en = 1'b1;
    tick();
    drv_en = 1'b0;
    probe(1'b1, 1'b1, 1'b0, 12'h020, 8'hA5, "reset_bus_release");
    reset_ = 1'b1;
    rd_check(12'h020, RST_EXP, "reset_contents", 1'b0);

    tick();
    tick();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
